// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the fetch unit: FSM states, exception cause
// codes and the instruction memory size used by the range check.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HANDLER = 2'd1,
    ST_HALT    = 2'd2
  } state_t;

  localparam logic [3:0] CAUSE_IRQ      = 4'b0001;
  localparam logic [3:0] CAUSE_ILLEGAL  = 4'b0010;
  localparam logic [3:0] CAUSE_MISALIGN = 4'b0100;
  localparam logic [3:0] CAUSE_RANGE    = 4'b1000;

  localparam int IMEM_BYTES = 512;

  // Instructions are 4-byte aligned; any low address bit set is a misaligned fetch.
  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_check.sv
// Combinational fetch fault detection: flags misaligned or out-of-range PCs
// and reports the cause, with misalignment taking precedence.
module fetch_check
  import fetch_unit_pkg::*;
#(
  parameter int N = 64
) (
  input  logic [N-1:0] pc,
  output logic         fault,
  output logic [3:0]   fault_cause
);

  logic misalign;
  logic out_of_range;

  assign misalign     = is_misaligned(pc[1:0]);
  assign out_of_range = pc >= N'(IMEM_BYTES);

  always_comb begin
    fault       = misalign | out_of_range;
    fault_cause = 4'b0000;
    if (misalign) begin
      fault_cause = CAUSE_MISALIGN;
    end else if (out_of_range) begin
      fault_cause = CAUSE_RANGE;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Program counter and exception FSM (RUN / HANDLER / HALT) for a small core
// fetching from a 512-byte instruction memory.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int           N      = 64,
  parameter logic [N-1:0] VECTOR = N'(64'h00D8)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         PCSrc,
  input  logic [N-1:0] PCBranch,
  input  logic         ExcReq,
  input  logic [3:0]   ExcCause,
  input  logic         ERet,
  output logic [6:0]   imem_addr,
  output logic [N-1:0] PC,
  output logic         FetchValid,
  output logic [N-1:0] EPC,
  output logic [3:0]   ESR,
  output logic         InHandler,
  output logic         Halted,
  output state_t       dbg_state
);

  state_t       state;
  logic [N-1:0] pc_q;
  logic [N-1:0] epc_q;
  logic [3:0]   esr_q;
  logic         in_handler_q;
  logic         halted_q;

  logic         fault;
  logic [3:0]   fault_cause;
  logic         exc_take;
  logic [3:0]   exc_cause;
  logic [N-1:0] pc_plus4;

  fetch_check #(.N(N)) u_check (
    .pc          (pc_q),
    .fault       (fault),
    .fault_cause (fault_cause)
  );

  // A faulting fetch squashes its own instruction, so ExcReq only counts on a valid fetch.
  assign exc_take  = fault | (ExcReq & ~fault);
  assign exc_cause = fault ? fault_cause : ExcCause;
  assign pc_plus4  = pc_q + N'(4);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_RUN;
      pc_q         <= '0;
      epc_q        <= '0;
      esr_q        <= 4'b0000;
      in_handler_q <= 1'b0;
      halted_q     <= 1'b0;
    end else if (!stall) begin
      case (state)
        ST_RUN: begin
          if (exc_take) begin
            pc_q         <= VECTOR;
            epc_q        <= pc_q;
            esr_q        <= exc_cause;
            state        <= ST_HANDLER;
            in_handler_q <= 1'b1;
          end else if (PCSrc) begin
            pc_q <= PCBranch;
          end else begin
            pc_q <= pc_plus4;
          end
        end
        ST_HANDLER: begin
          // Nested requests are ignored; only a fault inside the handler is fatal.
          if (fault) begin
            state        <= ST_HALT;
            in_handler_q <= 1'b0;
            halted_q     <= 1'b1;
          end else if (ERet) begin
            pc_q         <= epc_q;
            state        <= ST_RUN;
            in_handler_q <= 1'b0;
          end else if (PCSrc) begin
            pc_q <= PCBranch;
          end else begin
            pc_q <= pc_plus4;
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state        <= ST_RUN;
          in_handler_q <= 1'b0;
          halted_q     <= 1'b0;
        end
      endcase
    end
  end

  assign PC         = pc_q;
  assign imem_addr  = pc_q[8:2];
  assign FetchValid = ~fault;
  assign EPC        = epc_q;
  assign ESR        = esr_q;
  assign InHandler  = in_handler_q;
  assign Halted     = halted_q;
  assign dbg_state  = state;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: each cycle pushes the hand-derived expected
// outputs to a queue, then pops and compares them one step after the clock edge.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int W = 64 + 64 + 4 + 1 + 1;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        PCSrc;
  logic [63:0] PCBranch;
  logic        ExcReq;
  logic [3:0]  ExcCause;
  logic        ERet;
  logic [6:0]  imem_addr;
  logic [63:0] PC;
  logic        FetchValid;
  logic [63:0] EPC;
  logic [3:0]  ESR;
  logic        InHandler;
  logic        Halted;
  state_t      dbg_state;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  fetch_unit #(.N(64), .VECTOR(64'h00D8)) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .PCSrc      (PCSrc),
    .PCBranch   (PCBranch),
    .ExcReq     (ExcReq),
    .ExcCause   (ExcCause),
    .ERet       (ERet),
    .imem_addr  (imem_addr),
    .PC         (PC),
    .FetchValid (FetchValid),
    .EPC        (EPC),
    .ESR        (ESR),
    .InHandler  (InHandler),
    .Halted     (Halted),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // driver tasks
  task automatic drive(input logic s, input logic br_en, input logic [63:0] br,
                       input logic exc, input logic [3:0] cause, input logic er);
    stall    = s;
    PCSrc    = br_en;
    PCBranch = br;
    ExcReq   = exc;
    ExcCause = cause;
    ERet     = er;
  endtask

  task automatic push_exp(input logic [63:0] pc, input logic [63:0] epc,
                          input logic [3:0] esr, input logic inh, input logic halt);
    exp_q.push_back({pc, epc, esr, inh, halt});
  endtask

  // scoreboard: pop the oldest expectation and compare every output
  task automatic compare_outputs();
    logic [W-1:0] e;
    logic [63:0]  e_pc;
    logic [63:0]  e_epc;
    logic [3:0]   e_esr;
    logic         e_inh;
    logic         e_halt;
    logic         e_valid;
    if (exp_q.size() == 0) begin
      check("exp_queue_empty", 64'd1, 64'd0);
      return;
    end
    e = exp_q.pop_front();
    {e_pc, e_epc, e_esr, e_inh, e_halt} = e;
    e_valid = (e_pc[1:0] == 2'b00) && (e_pc < 64'd512);
    check("pc", PC, e_pc);
    check("imem_addr", {57'd0, imem_addr}, {57'd0, e_pc[8:2]});
    check("fetch_valid", {63'd0, FetchValid}, {63'd0, e_valid});
    check("epc", EPC, e_epc);
    check("esr", {60'd0, ESR}, {60'd0, e_esr});
    check("in_handler", {63'd0, InHandler}, {63'd0, e_inh});
    check("halted", {63'd0, Halted}, {63'd0, e_halt});
  endtask

  task automatic cycle(input logic s, input logic br_en, input logic [63:0] br,
                       input logic exc, input logic [3:0] cause, input logic er,
                       input logic [63:0] pc, input logic [63:0] epc,
                       input logic [3:0] esr, input logic inh, input logic halt);
    drive(s, br_en, br, exc, cause, er);
    push_exp(pc, epc, esr, inh, halt);
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic idle(input logic [63:0] pc, input logic [63:0] epc,
                      input logic [3:0] esr, input logic inh, input logic halt);
    cycle(1'b0, 1'b0, 64'd0, 1'b0, 4'd0, 1'b0, pc, epc, esr, inh, halt);
  endtask

  // Asserts reset between edges, checks the cleared state, releases after an edge.
  task automatic do_reset();
    drive(1'b0, 1'b0, 64'd0, 1'b0, 4'd0, 1'b0);
    reset = 1'b0;
    #1;
    push_exp(64'd0, 64'd0, 4'd0, 1'b0, 1'b0);
    compare_outputs();
    @(posedge clk);
    #1;
    push_exp(64'd0, 64'd0, 4'd0, 1'b0, 1'b0);
    compare_outputs();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 1'b0, 64'd0, 1'b0, 4'd0, 1'b0);
    #3;
    do_reset();

    // sequential fetch after reset
    idle(64'h4, 64'h0, 4'h0, 1'b0, 1'b0);
    idle(64'h8, 64'h0, 4'h0, 1'b0, 1'b0);

    // branch to a misaligned target faults on the next fetch
    cycle(1'b0, 1'b1, 64'h22, 1'b0, 4'd0, 1'b0, 64'h22, 64'h0, 4'h0, 1'b0, 1'b0);
    idle(64'hD8, 64'h22, CAUSE_MISALIGN, 1'b1, 1'b0);
    idle(64'hDC, 64'h22, CAUSE_MISALIGN, 1'b1, 1'b0);

    // external exception, nested request ignored, return
    do_reset();
    idle(64'h4, 64'h0, 4'h0, 1'b0, 1'b0);
    idle(64'h8, 64'h0, 4'h0, 1'b0, 1'b0);
    idle(64'hC, 64'h0, 4'h0, 1'b0, 1'b0);
    idle(64'h10, 64'h0, 4'h0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 64'd0, 1'b1, CAUSE_ILLEGAL, 1'b0, 64'hD8, 64'h10, CAUSE_ILLEGAL, 1'b1, 1'b0);
    idle(64'hDC, 64'h10, CAUSE_ILLEGAL, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 64'd0, 1'b1, CAUSE_IRQ, 1'b0, 64'hE0, 64'h10, CAUSE_ILLEGAL, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 64'd0, 1'b0, 4'd0, 1'b1, 64'h10, 64'h10, CAUSE_ILLEGAL, 1'b0, 1'b0);
    idle(64'h14, 64'h10, CAUSE_ILLEGAL, 1'b0, 1'b0);

    // ExcReq and ERet together in the handler: ERet wins
    cycle(1'b0, 1'b0, 64'd0, 1'b1, CAUSE_IRQ, 1'b0, 64'hD8, 64'h14, CAUSE_IRQ, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 64'd0, 1'b1, CAUSE_ILLEGAL, 1'b1, 64'h14, 64'h14, CAUSE_IRQ, 1'b0, 1'b0);
    // ERet outside the handler is a no-op
    cycle(1'b0, 1'b0, 64'd0, 1'b0, 4'd0, 1'b1, 64'h18, 64'h14, CAUSE_IRQ, 1'b0, 1'b0);
    idle(64'h1C, 64'h14, CAUSE_IRQ, 1'b0, 1'b0);
    idle(64'h20, 64'h14, CAUSE_IRQ, 1'b0, 1'b0);

    // stall drops events and freezes state
    cycle(1'b1, 1'b1, 64'h100, 1'b1, CAUSE_ILLEGAL, 1'b0, 64'h20, 64'h14, CAUSE_IRQ, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 64'h100, 1'b1, CAUSE_ILLEGAL, 1'b1, 64'h20, 64'h14, CAUSE_IRQ, 1'b0, 1'b0);
    idle(64'h24, 64'h14, CAUSE_IRQ, 1'b0, 1'b0);

    // fault inside the handler halts; halt ignores everything
    cycle(1'b0, 1'b0, 64'd0, 1'b1, CAUSE_ILLEGAL, 1'b0, 64'hD8, 64'h24, CAUSE_ILLEGAL, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 64'h200, 1'b0, 4'd0, 1'b0, 64'h200, 64'h24, CAUSE_ILLEGAL, 1'b1, 1'b0);
    idle(64'h200, 64'h24, CAUSE_ILLEGAL, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 64'(4 * $urandom_range(0, 100)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            64'h200, 64'h24, CAUSE_ILLEGAL, 1'b0, 1'b1);
    end
    do_reset();
    idle(64'h4, 64'h0, 4'h0, 1'b0, 1'b0);
    idle(64'h8, 64'h0, 4'h0, 1'b0, 1'b0);

    // misalign beats range when both apply
    cycle(1'b0, 1'b1, 64'h203, 1'b0, 4'd0, 1'b0, 64'h203, 64'h0, 4'h0, 1'b0, 1'b0);
    idle(64'hD8, 64'h203, CAUSE_MISALIGN, 1'b1, 1'b0);

    // range-only fault; return re-faults at the same PC
    do_reset();
    cycle(1'b0, 1'b1, 64'h300, 1'b0, 4'd0, 1'b0, 64'h300, 64'h0, 4'h0, 1'b0, 1'b0);
    idle(64'hD8, 64'h300, CAUSE_RANGE, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 64'd0, 1'b0, 4'd0, 1'b1, 64'h300, 64'h300, CAUSE_RANGE, 1'b0, 1'b0);
    idle(64'hD8, 64'h300, CAUSE_RANGE, 1'b1, 1'b0);

    // top-of-space branch target faults by range
    do_reset();
    cycle(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 4'd0, 1'b0,
          64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 4'h0, 1'b0, 1'b0);
    idle(64'hD8, 64'hFFFF_FFFF_FFFF_FFFC, CAUSE_RANGE, 1'b1, 1'b0);

    // final report
    if (exp_q.size() != 0) check("exp_queue_leftover", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
